bounded_counter: RTL
====================

# bounded_counter

Parametrised bounded counter for the counter and sequencer group: counts between a programmable lower and upper bound in a configurable step size. It supports up/down direction, saturate, wrap and bounce modes, synchronous load and clear, and a one-cycle terminal-count pulse. It replaces fixed-range ad-hoc counters and sits between control logic (start, enable, load) and downstream consumers of `q` and `tc`.

## Interface
- `WIDTH`, 4: counter width in bits.
- `MIN_VAL`, 2: lower bound, also the reset value.
- `MAX_VAL`, 10: upper bound. Legal range is `MIN_VAL < MAX_VAL <= 2^WIDTH-1`.
- `STEP`, 1: increment per step. Legal range is `1 <= STEP <= MAX_VAL-MIN_VAL`.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `en`, input, 1: step enable, honoured only in RUN.
- `start`, input, 1: IDLE to RUN; latches `dir` and `mode`.
- `dir`, input, 1: 1 = up, 0 = down.
- `mode`, input, 2: 00 saturate/stop, 01 wrap, 10 bounce, 11 treated as 00.
- `load`, input, 1: synchronous load of `load_val`.
- `load_val`, input, WIDTH: load value, clamped to `[MIN_VAL, MAX_VAL]`.
- `clr`, input, 1: synchronous clear.
- `q`, output, WIDTH: count value, registered.
- `tc`, output, 1: terminal-count pulse, registered, one cycle per boundary event.
- `busy`, output, 1: high while in RUN.

## Operation
- States:
  - IDLE: waiting for `start`.
  - RUN: counting.
  - DONE: saturate mode has hit its bound.
- Transitions:
  - IDLE to RUN on `start`.
  - RUN to DONE on a saturate-mode boundary event.
  - DONE to RUN on `start`.
  - Any state to IDLE on `clr`.
  - DONE to IDLE on `load`.
- `start` in RUN is ignored.
- Priority per edge: `clr` > `load` > `start` > step.
  - `clr`: `q`=MIN_VAL, state IDLE, `tc`=0.
  - `load`: `q`=clamp(`load_val`). IDLE and RUN are unchanged, DONE goes to IDLE. `tc`=0. Internal direction is re-latched from `dir`.
- Step rule: in RUN with `en`=1, compute the next value in WIDTH+1 bits with no overflow.
  - Up: if `q+STEP <= MAX_VAL`, `q += STEP`; otherwise this is a boundary event.
  - Down: if `q >= MIN_VAL+STEP`, `q -= STEP`; otherwise this is a boundary event.
- Boundary event, up direction:
  - Saturate: `q`=MAX_VAL, go to DONE.
  - Wrap: `q`=MIN_VAL.
  - Bounce: `q`=MAX_VAL and the internal direction flips.
- Boundary event, down direction: mirror image of the up case.
- A step that lands exactly on a bound is not a boundary event. The next step that would cross the bound is.
- `tc`=1 for exactly the one cycle following a boundary event. `tc` is 0 at all other times.
- In DONE, `q` holds and `en` has no effect.
- Latched `dir`/`mode` are used throughout RUN. Changing the inputs mid-run has no effect until the next `start` or `load`.

## Timing
- Reset (async, while `rst_n`=0): `q`=MIN_VAL, `tc`=0, `busy`=0, state IDLE, internal direction up. Release is synchronous to `clk`.
- `start` sampled at edge k: `busy`=1 after edge k. The first step can occur at edge k+1.
- Step latency is one cycle: `q` updates on the edge where `en`=1 is sampled.
- `tc` and the boundary `q` value appear on the same edge, so `tc` is aligned with the post-event `q`.
- `busy` falls on the same edge DONE is entered, i.e. coincident with `tc`.
- `load` or `clr` in the same cycle as a boundary event: `load`/`clr` wins and `tc` stays 0.
- `rst_n` asserted mid-RUN: outputs go to reset values immediately, without waiting for `clk`.

## Test plan
- Reset with defaults, `rst_n` held low, `clk` toggling: `q`=2, `tc`=0, `busy`=0. Deassert `rst_n`: outputs unchanged.
- Saturate up:
  - Stimulus: `start`, `dir`=1, `mode`=00, `en`=1.
  - `q` goes 3, 4, ..., 10 on 8 consecutive edges. The next edge is the boundary event: `tc`=1 for one cycle with `q`=10, `busy` drops, state DONE.
  - 5 further `en` cycles: `q` stays 10, `tc` stays 0.
- Wrap down:
  - Stimulus: `load_val`=4, `load`, then `start`, `dir`=0, `mode`=01, `en`=1.
  - `q` goes 3, 2, then 10 with `tc`=1, then 9. `busy` stays 1.
- Bounce, instance `STEP`=3, starting at `q`=2 going up:
  - `q` goes 5, 8, then 10 (`tc`=1), 7, 4, then 2 (`tc`=1), 5.
- Load and clear:
  - `load_val`=14: `q`=10. `load_val`=0: `q`=2.
  - `load`=1 with `en`=1 in RUN: load value wins, no step.
  - `clr`=1 together with `load`=1: `q`=2, state IDLE.
- Async reset mid-count: drop `rst_n` at `q`=7 between edges. `q`=2 and `busy`=0 before the next `clk` edge. After release, `start` is needed to resume counting.

Source files
------------

// File: rtl/bounded_counter.sv
`default_nettype none
// ============================================================================
//  Module   : bounded_counter
//  Purpose  : Parametrised counter running between MIN_VAL and MAX_VAL in
//             steps of STEP. Supports up/down counting and three behaviours
//             at a bound: saturate (stop), wrap and bounce. Also provides
//             synchronous load/clear and a one-cycle terminal-count pulse.
//  Ports    : clk      - rising-edge clock
//             rst_n    - asynchronous active-low reset
//             en       - step enable (only honoured while running)
//             start    - IDLE/DONE -> RUN, latches dir and mode
//             dir      - 1 = up, 0 = down
//             mode     - 00 saturate, 01 wrap, 10 bounce, 11 as 00
//             load     - synchronous load of clamped load_val
//             load_val - value to load
//             clr      - synchronous clear to MIN_VAL / IDLE
//             q        - registered count value
//             tc       - registered terminal-count pulse
//             busy     - high while running
//  Revision : 1.0 - initial release
// ============================================================================
module bounded_counter #(
    parameter int WIDTH   = 4,
    parameter int MIN_VAL = 2,
    parameter int MAX_VAL = 10,
    parameter int STEP    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy
);

    localparam logic [WIDTH-1:0] c_min    = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] c_max    = WIDTH'(MAX_VAL);
    localparam logic [WIDTH:0]   c_max_x  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   c_step_x = (WIDTH+1)'(STEP);
    // Smallest value from which a full down step stays in range.
    localparam logic [WIDTH:0]   c_dn_lim = (WIDTH+1)'(MIN_VAL + STEP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_q, w_q_nxt;
    logic             r_tc, w_tc_nxt;
    logic             r_dir_up, w_dir_up_nxt;
    logic [1:0]       r_mode, w_mode_nxt;

    logic [WIDTH:0]   w_up_sum;
    logic [WIDTH:0]   w_dn_diff;
    logic             w_up_ok;
    logic             w_dn_ok;
    logic             w_wrap;
    logic             w_bounce;
    logic [WIDTH-1:0] w_load_clamped;

    // Arithmetic is done one bit wider so the bound tests never overflow.
    assign w_up_sum  = {1'b0, r_q} + c_step_x;
    assign w_dn_diff = {1'b0, r_q} - c_step_x;
    assign w_up_ok   = (w_up_sum <= c_max_x);
    assign w_dn_ok   = ({1'b0, r_q} >= c_dn_lim);

    // Mode 11 decodes to neither, so it falls through to saturate.
    assign w_wrap   = (r_mode == 2'b01);
    assign w_bounce = (r_mode == 2'b10);

    always_comb begin
        if (load_val < c_min)
            w_load_clamped = c_min;
        else if (load_val > c_max)
            w_load_clamped = c_max;
        else
            w_load_clamped = load_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_q      <= c_min;
            r_tc     <= 1'b0;
            r_dir_up <= 1'b1;
            r_mode   <= 2'b00;
        end else begin
            r_state  <= w_state_nxt;
            r_q      <= w_q_nxt;
            r_tc     <= w_tc_nxt;
            r_dir_up <= w_dir_up_nxt;
            r_mode   <= w_mode_nxt;
        end
    end

    // Priority: clr > load > start > step.
    always_comb begin
        w_state_nxt  = r_state;
        w_q_nxt      = r_q;
        w_tc_nxt     = 1'b0;
        w_dir_up_nxt = r_dir_up;
        w_mode_nxt   = r_mode;

        if (clr) begin
            w_q_nxt     = c_min;
            w_state_nxt = ST_IDLE;
        end else if (load) begin
            w_q_nxt      = w_load_clamped;
            w_dir_up_nxt = dir;
            if (r_state == ST_DONE)
                w_state_nxt = ST_IDLE;
        end else if (start && (r_state != ST_RUN)) begin
            w_state_nxt  = ST_RUN;
            w_dir_up_nxt = dir;
            w_mode_nxt   = mode;
        end else if ((r_state == ST_RUN) && en) begin
            if (r_dir_up) begin
                if (w_up_ok) begin
                    w_q_nxt = w_up_sum[WIDTH-1:0];
                end else begin
                    w_tc_nxt = 1'b1;
                    if (w_wrap) begin
                        w_q_nxt = c_min;
                    end else if (w_bounce) begin
                        w_q_nxt      = c_max;
                        w_dir_up_nxt = 1'b0;
                    end else begin
                        w_q_nxt     = c_max;
                        w_state_nxt = ST_DONE;
                    end
                end
            end else begin
                if (w_dn_ok) begin
                    w_q_nxt = w_dn_diff[WIDTH-1:0];
                end else begin
                    w_tc_nxt = 1'b1;
                    if (w_wrap) begin
                        w_q_nxt = c_max;
                    end else if (w_bounce) begin
                        w_q_nxt      = c_min;
                        w_dir_up_nxt = 1'b1;
                    end else begin
                        w_q_nxt     = c_min;
                        w_state_nxt = ST_DONE;
                    end
                end
            end
        end
    end

    assign q    = r_q;
    assign tc   = r_tc;
    assign busy = (r_state == ST_RUN);

endmodule
`default_nettype wire
